// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes framed UART commands into register-file strobes and
// returns read data to the UART transmitter over a valid/busy handshake.
//   write frame : WR_CMD, addr, data
//   read frame  : RD_CMD, addr  -> one byte of read data is transmitted back
// Optional build macro CMD_TIMEOUT_EN adds an inter-byte gap timeout that
// aborts a partially received frame after TIMEOUT_CYCLES idle cycles.
module uart_cmd_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter logic [7:0]  WR_CMD         = 8'hAA,
   parameter logic [7:0]  RD_CMD         = 8'hBB,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic                  RX_PAR_ERR,
   input  logic                  RX_STP_ERR,
   input  logic [7:0]            RF_RD_DATA,
   input  logic                  RF_RD_VLD,
   input  logic                  TX_BUSY,
   output logic [ADDR_WIDTH-1:0] RF_ADDR,
   output logic [7:0]            RF_WR_DATA,
   output logic                  RF_WR_EN,
   output logic                  RF_RD_EN,
   output logic [7:0]            TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  CMD_ERR
);

   localparam int unsigned ByteW = 8;
   localparam int unsigned GapW  = 13;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_REQ  = 3'd5,
      TX_DONE = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [ByteW-1:0]      rf_wr_data_q, rf_wr_data_d;
   logic                  rf_wr_en_q, rf_wr_en_d;
   logic                  rf_rd_en_q, rf_rd_en_d;
   logic [ByteW-1:0]      tx_p_data_q, tx_p_data_d;
   logic                  tx_d_vld_q, tx_d_vld_d;
   logic                  cmd_err_q, cmd_err_d;
   logic                  busy_seen_q, busy_seen_d;

   logic                  good_byte_c;
   logic                  bad_byte_c;
   logic                  in_frame_c;
   logic                  timeout_c;

   // Byte qualification and "partial frame in progress" decode
   assign good_byte_c = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
   assign bad_byte_c  = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);
   assign in_frame_c  = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                        (state_q == RD_ADDR);

`ifdef CMD_TIMEOUT_EN
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

   // Timeout fires once the gap counter has reached the limit with no byte arriving
   assign timeout_c = in_frame_c && !RX_D_VLD &&
                      (gap_cnt_q >= GapW'(TIMEOUT_CYCLES));

   // Gap counter: counts silent cycles mid-frame, saturates, cleared elsewhere
   always_comb begin
      gap_cnt_d = '0;
      if (in_frame_c && !RX_D_VLD && !timeout_c) begin
         if (gap_cnt_q != '1) begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
         end else begin
            gap_cnt_d = gap_cnt_q;
         end
      end
   end

   // Gap counter register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         gap_cnt_q <= '0;
      end else begin
         gap_cnt_q <= gap_cnt_d;
      end
   end
`else
   logic unused_timeout;

   // No gap timeout: partial frames wait indefinitely
   assign timeout_c      = 1'b0;
   assign unused_timeout = ^GapW'(TIMEOUT_CYCLES);
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      rf_addr_d    = rf_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      tx_p_data_d  = tx_p_data_q;
      tx_d_vld_d   = 1'b0;
      cmd_err_d    = 1'b0;
      busy_seen_d  = busy_seen_q;

      case (state_q)
         IDLE: begin
            busy_seen_d = 1'b0;
            if (bad_byte_c) begin
               cmd_err_d = 1'b1;
            end else if (good_byte_c) begin
               if (RX_P_DATA == WR_CMD) begin
                  state_d = WR_ADDR;
               end else if (RX_P_DATA == RD_CMD) begin
                  state_d = RD_ADDR;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end

         WR_ADDR: begin
            if (bad_byte_c || timeout_c) begin
               cmd_err_d = 1'b1;
               state_d   = IDLE;
            end else if (good_byte_c) begin
               rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d   = WR_DATA;
            end
         end

         WR_DATA: begin
            if (bad_byte_c || timeout_c) begin
               cmd_err_d = 1'b1;
               state_d   = IDLE;
            end else if (good_byte_c) begin
               rf_wr_data_d = RX_P_DATA;
               rf_wr_en_d   = 1'b1;
               state_d      = IDLE;
            end
         end

         RD_ADDR: begin
            if (bad_byte_c || timeout_c) begin
               cmd_err_d = 1'b1;
               state_d   = IDLE;
            end else if (good_byte_c) begin
               rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               rf_rd_en_d = 1'b1;
               state_d    = RD_WAIT;
            end
         end

         RD_WAIT: begin
            // Stray bytes are flagged but never disturb the read in flight
            cmd_err_d = RX_D_VLD;
            if (RF_RD_VLD) begin
               tx_p_data_d = RF_RD_DATA;
               state_d     = TX_REQ;
            end
         end

         TX_REQ: begin
            cmd_err_d = RX_D_VLD;
            if (tx_d_vld_q && !TX_BUSY) begin
               busy_seen_d = 1'b0;
               state_d     = TX_DONE;
            end else begin
               tx_d_vld_d = !TX_BUSY;
            end
         end

         TX_DONE: begin
            // Wait for the transmitter to go busy and then idle again
            cmd_err_d = RX_D_VLD;
            if (TX_BUSY) begin
               busy_seen_d = 1'b1;
            end else if (busy_seen_q) begin
               busy_seen_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         rf_addr_q    <= '0;
         rf_wr_data_q <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         tx_p_data_q  <= '0;
         tx_d_vld_q   <= 1'b0;
         cmd_err_q    <= 1'b0;
         busy_seen_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rf_addr_q    <= rf_addr_d;
         rf_wr_data_q <= rf_wr_data_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_en_q   <= rf_rd_en_d;
         tx_p_data_q  <= tx_p_data_d;
         tx_d_vld_q   <= tx_d_vld_d;
         cmd_err_q    <= cmd_err_d;
         busy_seen_q  <= busy_seen_d;
      end
   end

   assign RF_ADDR    = rf_addr_q;
   assign RF_WR_DATA = rf_wr_data_q;
   assign RF_WR_EN   = rf_wr_en_q;
   assign RF_RD_EN   = rf_rd_en_q;
   assign TX_P_DATA  = tx_p_data_q;
   assign TX_D_VLD   = tx_d_vld_q;
   assign CMD_ERR    = cmd_err_q;

endmodule
